// File: rtl/regfile_mp.sv
// regfile_mp
// Multi-port register file for decode/writeback: NUM_RD registered read
// ports, two write ports (port 1 wins on an address collision), same-cycle
// write-to-read bypass and an optional hardwired-zero register 0.
// The array has no reset; a counter-driven clear sequencer zeroes it
// after reset or on a clr request so the storage stays RAM-inferable.
//
// Ports
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   clr              synchronous request to re-zero every register
//   busy             clear sequence running; all accesses ignored
//   rd_en[i]         read enable, port i
//   rd_addr          read addresses, port i at [i*ADDR_W +: ADDR_W]
//   rd_data          registered read data, port i at [i*DATA_W +: DATA_W]
//   we0/wa0/wd0      write port 0
//   we1/wa1/wd1      write port 1 (higher priority)
module regfile_mp #(
    parameter int DATA_W   = 32,
    parameter int DEPTH    = 32,
    parameter int ADDR_W   = 5,
    parameter int NUM_RD   = 2,
    parameter int ZERO_REG = 1
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr,
    output logic                     busy,
    input  logic [NUM_RD-1:0]        rd_en,
    input  logic [NUM_RD*ADDR_W-1:0] rd_addr,
    output logic [NUM_RD*DATA_W-1:0] rd_data,
    input  logic                     we0,
    input  logic                     we1,
    input  logic [ADDR_W-1:0]        wa0,
    input  logic [ADDR_W-1:0]        wa1,
    input  logic [DATA_W-1:0]        wd0,
    input  logic [DATA_W-1:0]        wd1
);

    typedef enum logic {CLEAR, RUN} state_t;

    state_t              state, state_nxt;
    logic [ADDR_W-1:0]   clr_cnt, clr_cnt_nxt;
    logic [DATA_W-1:0]   mem [DEPTH];

    logic [NUM_RD-1:0][DATA_W-1:0] rd_q;
    logic [NUM_RD-1:0][DATA_W-1:0] rd_nxt;

    logic we0_eff, we1_eff;

    // Address maps to a real, writable/readable register (not the
    // hardwired zero and not past DEPTH).
    function automatic logic live_addr(input logic [ADDR_W-1:0] a);
        logic ok;
        ok = (32'(a) < 32'(DEPTH));
        if (ZERO_REG != 0 && a == '0)
            ok = 1'b0;
        return ok;
    endfunction

    // A clr request in RUN drops the writes of that cycle, which also
    // removes them from the bypass path.
    assign we0_eff = (state == RUN) && !clr && we0 && live_addr(wa0);
    assign we1_eff = (state == RUN) && !clr && we1 && live_addr(wa1);

    assign busy    = (state == CLEAR);
    assign rd_data = rd_q;

    // ---------------------------------------------------------------
    // Clear sequencer
    // ---------------------------------------------------------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nxt;
            clr_cnt <= clr_cnt_nxt;
        end
    end

    always_comb begin
        state_nxt   = state;
        clr_cnt_nxt = clr_cnt;
        case (state)
            CLEAR: begin
                if (clr) begin
                    clr_cnt_nxt = '0;
                end else if (clr_cnt == ADDR_W'(DEPTH - 1)) begin
                    state_nxt   = RUN;
                    clr_cnt_nxt = '0;
                end else begin
                    clr_cnt_nxt = clr_cnt + 1'b1;
                end
            end
            RUN: begin
                if (clr) begin
                    state_nxt   = CLEAR;
                    clr_cnt_nxt = '0;
                end
            end
            default: begin
                state_nxt   = CLEAR;
                clr_cnt_nxt = '0;
            end
        endcase
    end

    // ---------------------------------------------------------------
    // Storage: no reset so it maps onto RAM. Port 1 is written last so
    // it wins when both ports hit the same address.
    // ---------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (state == CLEAR) begin
            mem[clr_cnt] <= '0;
        end else begin
            if (we0_eff)
                mem[wa0] <= wd0;
            if (we1_eff)
                mem[wa1] <= wd1;
        end
    end

    // ---------------------------------------------------------------
    // Read ports
    // ---------------------------------------------------------------
    always_comb begin
        for (int p = 0; p < NUM_RD; p++) begin
            logic [ADDR_W-1:0] a;
            a         = rd_addr[p*ADDR_W +: ADDR_W];
            rd_nxt[p] = '0;
            if (live_addr(a)) begin
                if (we1_eff && wa1 == a)
                    rd_nxt[p] = wd1;
                else if (we0_eff && wa0 == a)
                    rd_nxt[p] = wd0;
                else
                    rd_nxt[p] = mem[a];
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_q <= '0;
        end else begin
            for (int p = 0; p < NUM_RD; p++) begin
                if (state == CLEAR)
                    rd_q[p] <= '0;
                else if (rd_en[p])
                    rd_q[p] <= rd_nxt[p];
            end
        end
    end

endmodule

// File: tb/tb_regfile_mp.sv
module tb_regfile_mp;

    localparam int DW = 32;
    localparam int D  = 32;
    localparam int AW = 5;
    localparam int NR = 2;

    logic              clk   = 1'b0;
    logic              rst   = 1'b0;
    logic              rst24 = 1'b0;
    logic              clr   = 1'b0;
    logic              busy, busy24;
    logic [NR-1:0]     rd_en   = '0;
    logic [NR*AW-1:0]  rd_addr = '0;
    logic [NR*DW-1:0]  rd_data, rd_data24;
    logic              we0 = 1'b0, we1 = 1'b0;
    logic [AW-1:0]     wa0 = '0, wa1 = '0;
    logic [DW-1:0]     wd0 = '0, wd1 = '0;

    always #5 clk = ~clk;

    regfile_mp #(.DATA_W(DW), .DEPTH(D), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut (
        .clk(clk), .rst(rst), .clr(clr), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1)
    );

    // Shares every input except reset; used only for the DEPTH=24 checks.
    regfile_mp #(.DATA_W(DW), .DEPTH(24), .ADDR_W(AW), .NUM_RD(NR), .ZERO_REG(1)) u_dut24 (
        .clk(clk), .rst(rst24), .clr(clr), .busy(busy24),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data24),
        .we0(we0), .we1(we1), .wa0(wa0), .wa1(wa1), .wd0(wd0), .wd1(wd1)
    );

    typedef struct {
        int          dut;
        int          port;
        logic [31:0] exp;
        string       tag;
    } sb_t;

    sb_t         sb_q[$];
    logic [31:0] m [D];
    logic [31:0] mprev [NR];
    int          mcnt;
    int          n_chk = 0;
    int          n_err = 0;
    int          busy_seen;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] rdp(input logic [NR*DW-1:0] v, input int p);
        return v[p*DW +: DW];
    endfunction

    function automatic bit weff(input logic we, input logic [AW-1:0] a);
        return we && !clr && (a != '0) && (int'(a) < D);
    endfunction

    function automatic logic [31:0] model_rd(input logic [AW-1:0] a);
        if (a == '0 || int'(a) >= D) return 32'h0;
        if (weff(we1, wa1) && wa1 == a) return wd1;
        if (weff(we0, wa0) && wa0 == a) return wd0;
        return m[a];
    endfunction

    task automatic setrd(input int p, input logic [AW-1:0] a);
        rd_addr[p*AW +: AW] = a;
    endtask

    task automatic idle();
        rd_en = '0; we0 = 1'b0; we1 = 1'b0; clr = 1'b0;
    endtask

    // One clock: predict reads from the model, advance the model, clock,
    // then compare busy and every scoreboard entry.
    task automatic cyc();
        logic [31:0] e [NR];
        sb_t         s;
        if (busy) busy_seen++;
        for (int p = 0; p < NR; p++) begin
            if (mcnt > 0)      e[p] = 32'h0;
            else if (rd_en[p]) e[p] = model_rd(rd_addr[p*AW +: AW]);
            else               e[p] = mprev[p];
            sb_q.push_back('{0, p, e[p], $sformatf("rd%0d", p)});
        end
        if (mcnt > 0) begin
            if (clr) mcnt = D;
            else     mcnt--;
        end else if (clr) begin
            mcnt = D;
            foreach (m[i]) m[i] = 32'h0;
        end else begin
            if (weff(we0, wa0)) m[wa0] = wd0;
            if (weff(we1, wa1)) m[wa1] = wd1;
        end
        for (int p = 0; p < NR; p++) mprev[p] = e[p];
        @(posedge clk);
        #1;
        chk("busy", {31'b0, busy}, {31'b0, (mcnt > 0)});
        while (sb_q.size() > 0) begin
            s = sb_q.pop_front();
            chk(s.tag, (s.dut != 0) ? rdp(rd_data24, s.port) : rdp(rd_data, s.port), s.exp);
        end
    endtask

    // Asynchronous reset, asserted away from the clock edge.
    task automatic do_rst();
        idle();
        rst = 1'b1;
        #1;
        chk("rst_rd0", rdp(rd_data, 0), 32'h0);
        chk("rst_rd1", rdp(rd_data, 1), 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h1);
        mcnt = D;
        foreach (m[i]) m[i] = 32'h0;
        for (int p = 0; p < NR; p++) mprev[p] = 32'h0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        busy_seen = 0;
    endtask

    task automatic run_idle();
        idle();
        for (int k = 0; k < 200; k++) begin
            if (!busy && mcnt == 0) break;
            cyc();
        end
    endtask

    initial begin
        int b24;
        #2;
        rst24 = 1'b1;

        // Reset release: access during busy is ignored
        do_rst();
        rd_en = 2'b01; setrd(0, 5);
        we0 = 1'b1; wa0 = 5; wd0 = 32'h0000_DEAD;
        cyc();
        run_idle();
        chk("rst_busy_len", busy_seen, 32);
        rd_en = 2'b01; setrd(0, 5);
        cyc();

        // Write then read; same-cycle bypass
        idle(); we0 = 1'b1; wa0 = 7; wd0 = 32'h1234_5678;
        cyc();
        idle(); rd_en = 2'b01; setrd(0, 7);
        cyc();
        idle(); we0 = 1'b1; wa0 = 9; wd0 = 32'h9999_0009; rd_en = 2'b10; setrd(1, 9);
        cyc();

        // Write collision: port 1 wins, bypass too
        idle();
        we0 = 1'b1; wa0 = 3; wd0 = 32'hAAAA_0000;
        we1 = 1'b1; wa1 = 3; wd1 = 32'h5555_1111;
        rd_en = 2'b11; setrd(0, 3); setrd(1, 3);
        cyc();
        idle(); rd_en = 2'b11; setrd(0, 3); setrd(1, 9);
        cyc();

        // Hardwired zero register
        idle();
        we0 = 1'b1; wa0 = 0; wd0 = 32'hFFFF_FFFF;
        we1 = 1'b1; wa1 = 0; wd1 = 32'hFFFF_FFFF;
        rd_en = 2'b11; setrd(0, 0); setrd(1, 0);
        cyc();
        idle(); rd_en = 2'b11; setrd(0, 0); setrd(1, 7);
        cyc();

        // rd_en low holds data
        idle(); setrd(0, 3); setrd(1, 9);
        cyc();

        // Fill 1..31 with own index
        for (int i = 1; i < D; i += 2) begin
            idle();
            we0 = 1'b1; wa0 = AW'(i); wd0 = 32'(i);
            if (i + 1 < D) begin
                we1 = 1'b1; wa1 = AW'(i + 1); wd1 = 32'(i + 1);
            end
            cyc();
        end
        idle(); rd_en = 2'b11; setrd(0, 1); setrd(1, 31);
        cyc();

        // clr with concurrent writes (dropped) and reads (no bypass)
        idle();
        clr = 1'b1;
        we0 = 1'b1; wa0 = 1; wd0 = 32'h0000_0BAD;
        we1 = 1'b1; wa1 = 4; wd1 = 32'h0000_4444;
        rd_en = 2'b11; setrd(0, 2); setrd(1, 4);
        busy_seen = 0;
        cyc();
        idle();
        for (int k = 0; k < 9; k++) cyc();
        clr = 1'b1;
        cyc();
        run_idle();
        chk("clr_ext_len", busy_seen, 42);
        for (int a = 0; a < D; a += 2) begin
            idle(); rd_en = 2'b11; setrd(0, AW'(a)); setrd(1, AW'(a + 1));
            cyc();
        end

        // Reset mid-clear restarts a full clear
        idle(); clr = 1'b1;
        cyc();
        idle();
        for (int k = 0; k < 5; k++) cyc();
        do_rst();
        run_idle();
        chk("midclr_busy_len", busy_seen, 32);

        // Reset mid-read zeroes rd_data at once
        idle(); we0 = 1'b1; wa0 = 7; wd0 = 32'h0000_0077;
        cyc();
        idle(); rd_en = 2'b11; setrd(0, 7); setrd(1, 7);
        cyc();
        do_rst();
        run_idle();

        // DEPTH=24 instance: address 30 is out of range
        rst24 = 1'b0;
        b24 = 0;
        idle();
        for (int k = 0; k < 30; k++) begin
            if (busy24) b24++;
            cyc();
        end
        chk("d24_busy_len", b24, 24);
        chk("d24_busy", {31'b0, busy24}, 32'h0);
        idle(); we0 = 1'b1; wa0 = 30; wd0 = 32'h0000_CAFE; rd_en = 2'b01; setrd(0, 30);
        sb_q.push_back('{1, 0, 32'h0, "d24_byp30"});
        cyc();
        idle(); rd_en = 2'b01; setrd(0, 30);
        sb_q.push_back('{1, 0, 32'h0, "d24_rd30"});
        cyc();
        idle(); we0 = 1'b1; wa0 = 5; wd0 = 32'h0000_0055;
        cyc();
        idle(); rd_en = 2'b01; setrd(0, 5);
        sb_q.push_back('{1, 0, 32'h0000_0055, "d24_rd5"});
        cyc();

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout exp finish");
        $fatal(1, "watchdog");
    end

endmodule
